// File: rtl/fetch_buffer.sv
// Fetch buffer: a circular FIFO of {pc, instruction} pairs between instruction fetch and decode.
// The head entry is presented to decode from registered state; the PC controller is stalled early via buble.
module fetch_buffer #(
  parameter int size  = 32,
  parameter int depth = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     instruction_valid,
  input  logic [size-1:0]          instruction_i,
  input  logic [size-1:0]          pc_i,
  input  logic                     dec_ready,
  output logic                     dec_valid,
  output logic [size-1:0]          dec_instruction,
  output logic [size-1:0]          dec_pc,
  output logic                     buble,
  output logic [$clog2(depth):0]   count,
  output logic                     overflow
);

  localparam int aw = $clog2(depth);
  localparam int cw = aw + 1;

  logic [aw-1:0]     wr_ptr_reg;
  logic [aw-1:0]     rd_ptr_reg;
  logic [cw-1:0]     count_reg;
  logic [cw-1:0]     count_next;
  logic              overflow_reg;
  logic              full;
  logic              push;
  logic              pop;
  logic [depth-1:0]  wr_en;
  logic [2*size-1:0] mem [depth];

  assign full      = (count_reg == cw'(depth));
  assign dec_valid = (count_reg != '0);
  assign push      = instruction_valid & ~full & ~flush;
  assign pop       = dec_valid & dec_ready & ~flush;

  // One slot stays free for the fetch that is already in flight when the stall is raised.
  assign buble     = (count_reg >= cw'(depth - 1));
  assign count     = count_reg;
  assign overflow  = overflow_reg;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + cw'(1);
      2'b01:   count_next = count_reg - cw'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      // depth is a power of two, so the natural pointer rollover is the wrap to 0.
      if (push) wr_ptr_reg <= wr_ptr_reg + aw'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + aw'(1);
      count_reg <= count_next;
      if (instruction_valid && full) overflow_reg <= 1'b1;
    end
  end

  for (genvar gi = 0; gi < depth; gi++) begin : g_wr_en
    assign wr_en[gi] = push && (wr_ptr_reg == aw'(gi));
  end

  // Storage is not reset; its contents are only observed while dec_valid is high.
  always_ff @(posedge clk) begin
    for (int i = 0; i < depth; i++) begin
      if (wr_en[i]) mem[i] <= {pc_i, instruction_i};
    end
  end

  assign dec_pc          = mem[rd_ptr_reg][2*size-1:size];
  assign dec_instruction = mem[rd_ptr_reg][size-1:0];

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer (size=32, depth=4): pass-through, fill/overflow,
// simultaneous push/pop, wrap-around streaming, flush and mid-operation reset.
module tb_fetch_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        instruction_valid = 1'b0;
  logic [31:0] instruction_i = '0;
  logic [31:0] pc_i = '0;
  logic        dec_ready = 1'b0;
  logic        dec_valid;
  logic [31:0] dec_instruction;
  logic [31:0] dec_pc;
  logic        buble;
  logic [2:0]  count;
  logic        overflow;

  int total = 0;
  int bad = 0;

  fetch_buffer #(.size(32), .depth(4)) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .instruction_valid(instruction_valid),
    .instruction_i(instruction_i),
    .pc_i(pc_i),
    .dec_ready(dec_ready),
    .dec_valid(dec_valid),
    .dec_instruction(dec_instruction),
    .dec_pc(dec_pc),
    .buble(buble),
    .count(count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ins_of(input logic [31:0] pc);
    return pc + 32'h13;
  endfunction

  task automatic push_one(input logic [31:0] pc);
    instruction_valid = 1'b1;
    pc_i = pc;
    instruction_i = ins_of(pc);
    tick();
    instruction_valid = 1'b0;
  endtask

  initial begin
    int sent;
    int rcv;
    logic did_push;
    logic did_pop;

    // Reset state
    tick();
    reset = 1'b0;
    chk("rst_valid", 64'(dec_valid), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_buble", 64'(buble), 64'(0));
    chk("rst_overflow", 64'(overflow), 64'(0));

    // Single pass-through, no bypass
    dec_ready = 1'b1;
    instruction_valid = 1'b1;
    pc_i = 32'h8000_0000;
    instruction_i = 32'h0000_0013;
    #1;
    chk("no_bypass", 64'(dec_valid), 64'(0));
    tick();
    instruction_valid = 1'b0;
    chk("pt_valid", 64'(dec_valid), 64'(1));
    chk("pt_pc", 64'(dec_pc), 64'h8000_0000);
    chk("pt_ins", 64'(dec_instruction), 64'h0000_0013);
    tick();
    chk("pt_count0", 64'(count), 64'(0));
    chk("pt_valid0", 64'(dec_valid), 64'(0));

    // Fill and stall
    dec_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_one(32'h8000_0000 + 32'(4 * i));
      chk($sformatf("fill_count%0d", i), 64'(count), 64'(i + 1));
      chk($sformatf("fill_buble%0d", i), 64'(buble), 64'((i + 1) >= 3));
    end
    chk("fill_overflow_pre", 64'(overflow), 64'(0));
    push_one(32'h8000_0010);
    chk("ovf_set", 64'(overflow), 64'(1));
    chk("ovf_count", 64'(count), 64'(4));
    chk("ovf_head_pc", 64'(dec_pc), 64'h8000_0000);
    chk("ovf_head_ins", 64'(dec_instruction), 64'(ins_of(32'h8000_0000)));
    // Head stays stable while stalled
    tick();
    chk("stall_head_pc", 64'(dec_pc), 64'h8000_0000);

    // Drain to 2, then simultaneous push/pop
    dec_ready = 1'b1;
    tick();
    chk("pop_count3", 64'(count), 64'(3));
    chk("pop_head1", 64'(dec_pc), 64'h8000_0004);
    tick();
    chk("pop_count2", 64'(count), 64'(2));
    chk("pop_head2", 64'(dec_pc), 64'h8000_0008);
    push_one(32'h8000_0010);
    chk("pp_count_a", 64'(count), 64'(2));
    chk("pp_head_a", 64'(dec_pc), 64'h8000_000C);
    push_one(32'h8000_0014);
    chk("pp_count_b", 64'(count), 64'(2));
    chk("pp_head_b", 64'(dec_pc), 64'h8000_0010);
    chk("pp_ins_b", 64'(dec_instruction), 64'(ins_of(32'h8000_0010)));
    tick();
    chk("pp_head_c", 64'(dec_pc), 64'h8000_0014);
    chk("pp_count_c", 64'(count), 64'(1));
    tick();
    chk("pp_empty", 64'(dec_valid), 64'(0));
    chk("ovf_sticky", 64'(overflow), 64'(1));

    // Flush at count=3 with valid and ready in the same cycle
    dec_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_one(32'h9000_0000 + 32'(4 * i));
    chk("fl_pre_count", 64'(count), 64'(3));
    chk("fl_pre_buble", 64'(buble), 64'(1));
    flush = 1'b1;
    dec_ready = 1'b1;
    instruction_valid = 1'b1;
    pc_i = 32'h9000_000C;
    instruction_i = ins_of(32'h9000_000C);
    tick();
    flush = 1'b0;
    instruction_valid = 1'b0;
    dec_ready = 1'b0;
    chk("fl_count", 64'(count), 64'(0));
    chk("fl_valid", 64'(dec_valid), 64'(0));
    chk("fl_overflow", 64'(overflow), 64'(0));
    chk("fl_buble", 64'(buble), 64'(0));
    tick();
    chk("fl_never_delivered", 64'(dec_valid), 64'(0));
    push_one(32'h9000_0100);
    chk("fl_after_pc", 64'(dec_pc), 64'h9000_0100);
    chk("fl_after_count", 64'(count), 64'(1));
    dec_ready = 1'b1;
    tick();
    chk("fl_after_drain", 64'(count), 64'(0));

    // Wrap-around streaming with toggling ready; fetch honours buble
    sent = 0;
    rcv = 0;
    for (int cyc = 0; cyc < 200 && rcv < 10; cyc++) begin
      dec_ready = (cyc % 2 == 0);
      did_push = (sent < 10) && !buble;
      instruction_valid = did_push;
      pc_i = 32'hA000_0000 + 32'(4 * sent);
      instruction_i = ins_of(pc_i);
      #1;
      did_pop = dec_valid && dec_ready;
      if (did_pop) begin
        chk($sformatf("wrap_pc%0d", rcv), 64'(dec_pc), 64'(32'hA000_0000 + 32'(4 * rcv)));
      end
      tick();
      if (did_push) sent++;
      if (did_pop) rcv++;
    end
    instruction_valid = 1'b0;
    dec_ready = 1'b0;
    chk("wrap_received", 64'(rcv), 64'(10));
    chk("wrap_sent", 64'(sent), 64'(10));
    chk("wrap_empty", 64'(dec_valid), 64'(0));
    chk("wrap_no_ovf", 64'(overflow), 64'(0));

    // Reset at count=2 with overflow set
    for (int i = 0; i < 5; i++) push_one(32'hB000_0000 + 32'(4 * i));
    dec_ready = 1'b1;
    tick();
    tick();
    dec_ready = 1'b0;
    chk("rr_pre_count", 64'(count), 64'(2));
    chk("rr_pre_ovf", 64'(overflow), 64'(1));
    reset = 1'b1;
    instruction_valid = 1'b1;
    pc_i = 32'hB000_0100;
    tick();
    reset = 1'b0;
    instruction_valid = 1'b0;
    chk("rr_count", 64'(count), 64'(0));
    chk("rr_ovf", 64'(overflow), 64'(0));
    chk("rr_buble", 64'(buble), 64'(0));
    chk("rr_valid", 64'(dec_valid), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
